// File: rtl/sbox_table_loader.sv
// sbox_table_loader: streams bytes into a 1024x8 S-box BRAM and tracks their checksum.
// Define SBOX_LOADER_READBACK_EN to read the table back and verify it against that checksum.
module sbox_table_loader #(
  parameter int AW = 10,
  parameter int READ_LATENCY = 2,
  parameter int CSUM_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [7:0]        mem_din,
  input  logic [7:0]        mem_dout,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [CSUM_W-1:0] csum
);
  localparam logic [2:0] IDLE = 3'd0, LOAD = 3'd1;
  logic [2:0] state;
  logic [AW:0] wcnt;
  logic hs;
`ifdef SBOX_LOADER_READBACK_EN
  localparam logic [2:0] VRD = 3'd2, VDRAIN = 3'd3, CMP = 3'd4;
  localparam logic [AW:0] LAST = {1'b0, {AW{1'b1}}};
  logic [READ_LATENCY-1:0] vpipe;
  logic [AW:0] rcnt;
  logic [CSUM_W-1:0] rsum;
  logic tag;
  // the oldest pipe stage marks the cycle whose mem_dout belongs to a read we issued
  assign tag = vpipe[READ_LATENCY-1];
`else
  logic unused_dout;
  assign unused_dout = ^mem_dout ^ (READ_LATENCY == 0);
`endif
  // wcnt reaching DEPTH closes the stream while the last write is still in flight
  assign s_ready = (state == LOAD) && !wcnt[AW];
  assign hs = s_valid && s_ready;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      error <= 1'b0;
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_din <= '0;
      csum <= '0;
      wcnt <= '0;
`ifdef SBOX_LOADER_READBACK_EN
      vpipe <= '0;
      rcnt <= '0;
      rsum <= '0;
`endif
    end else begin
      done <= 1'b0;
`ifdef SBOX_LOADER_READBACK_EN
      vpipe <= READ_LATENCY'({vpipe, state == VRD});
      if (tag) begin
        rsum <= rsum + CSUM_W'(mem_dout);
        rcnt <= rcnt + 1'b1;
      end
`endif
      if (abort && (state != IDLE || start)) begin
        state <= IDLE;
        busy <= 1'b0;
        mem_en <= 1'b0;
        mem_we <= 1'b0;
        error <= 1'b1;
      end else begin
        case (state)
          IDLE: if (start) begin
            state <= LOAD;
            busy <= 1'b1;
            wcnt <= '0;
            csum <= '0;
            error <= 1'b0;
          end
          LOAD: begin
            mem_en <= hs;
            mem_we <= hs;
            if (hs) begin
              mem_addr <= wcnt[AW-1:0];
              mem_din <= s_data;
              wcnt <= wcnt + 1'b1;
              csum <= csum + CSUM_W'(s_data);
            end else if (wcnt[AW]) begin
`ifdef SBOX_LOADER_READBACK_EN
              state <= VRD;
              mem_en <= 1'b1;
              mem_addr <= '0;
              rcnt <= '0;
              rsum <= '0;
`else
              state <= IDLE;
              busy <= 1'b0;
              done <= 1'b1;
`endif
            end
          end
`ifdef SBOX_LOADER_READBACK_EN
          VRD: if (&mem_addr) state <= VDRAIN; else mem_addr <= mem_addr + 1'b1;
          // mem_en stays high here so the RAM output register delivers the last reads
          VDRAIN: if (tag && rcnt == LAST) begin
            state <= CMP;
            mem_en <= 1'b0;
          end
          CMP: begin
            state <= IDLE;
            busy <= 1'b0;
            done <= 1'b1;
            error <= rsum != csum;
          end
`endif
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_sbox_table_loader.sv
// tb_sbox_table_loader: randomized load/abort/reset scenarios checked every cycle
// against a transaction-level model of the loader and a 2-cycle-latency RAM.
module tb_sbox_table_loader;
  localparam int DEPTH = 1024;
`ifdef SBOX_LOADER_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif
  localparam int DONE_LAG = RB ? 1028 : 1;
  localparam int HS_TO_DONE = RB ? 1029 : 2;

  logic clk = 1'b0, rst_n = 1'b1;
  logic start = 1'b0, abort = 1'b0, s_valid = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic s_ready, mem_en, mem_we, busy, done, error;
  logic [9:0] mem_addr;
  logic [7:0] mem_din;
  logic [7:0] mem_dout = 8'h00;
  logic [15:0] csum;

  sbox_table_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .busy(busy), .done(done), .error(error), .csum(csum)
  );

  always #5 clk = ~clk;

  logic [7:0] ram [DEPTH];
  logic [7:0] ram_lat = 8'h00;
  bit corrupt = 1'b0;
  always @(posedge clk) if (mem_en) begin
    if (mem_we) ram[mem_addr] <= mem_din;
    ram_lat <= ram[mem_addr] ^ ((corrupt && mem_addr == 10'h155) ? 8'h01 : 8'h00);
    mem_dout <= ram_lat;
  end

  int cyc = 0, n = 0, done_at = -1, rb_start = -1;
  bit m_busy, m_load, m_err, m_we, m_en, m_done;
  logic [9:0] m_addr;
  logic [7:0] m_din;
  logic [15:0] m_sum;
  always @(posedge clk) begin
    cyc++;
    m_we = 1'b0;
    m_done = 1'b0;
    if (!rst_n) begin
      m_busy = 0; m_load = 0; m_err = 0; n = 0; m_sum = 0; done_at = -1; rb_start = -1;
    end else if (abort && (m_busy || start)) begin
      m_busy = 0; m_load = 0; m_err = 1; done_at = -1; rb_start = -1;
    end else if (start && !m_busy) begin
      m_busy = 1; m_load = 1; n = 0; m_sum = 0; m_err = 0; rb_start = -1;
    end else if (m_load && s_valid) begin
      m_we = 1;
      m_addr = 10'(n);
      m_din = s_data;
      m_sum += 16'(s_data);
      n++;
      if (n == DEPTH) begin
        m_load = 0;
        done_at = cyc + DONE_LAG;
        if (RB) rb_start = cyc + 1;
      end
    end
    if (cyc == done_at) begin
      m_done = 1; m_busy = 0; m_err = RB && corrupt;
    end
    m_en = m_we || (rb_start >= 0 && cyc >= rb_start && cyc < rb_start + DEPTH + 2);
  end

  int checks = 0, fails = 0, wr_cnt = 0, last_hs = 0;
  bit pat_mode = 1'b0;
  task automatic chk(string nm, longint act, longint exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
    end
  endtask

  initial forever begin
    @(negedge clk or negedge rst_n);
    if (!rst_n) begin
      #1;
      chk("reset outputs", {s_ready, mem_en, mem_we, busy, done, error, mem_addr, mem_din, csum}, 0);
    end else begin
      chk("s_ready", s_ready, m_load);
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("error", error, m_err);
      chk("mem_en", mem_en, m_en);
      chk("mem_we", mem_we, m_we);
      if (m_we) begin
        chk("wr addr", mem_addr, m_addr);
        chk("wr data", mem_din, m_din);
      end
      if (rb_start >= 0 && cyc >= rb_start && cyc < rb_start + DEPTH)
        chk("rd addr", mem_addr, cyc - rb_start);
      if (s_valid && s_ready) last_hs = cyc;
      if (mem_we) wr_cnt++;
      if (m_done) begin
        chk("csum", csum, m_sum);
        chk("write count", wr_cnt, DEPTH);
        chk("hs to done", cyc - last_hs, HS_TO_DONE);
        if (pat_mode) chk("csum pattern", csum, 16'hFE00);
      end
      if (!m_busy) wr_cnt = 0;
    end
  end

  logic [7:0] tab [DEPTH];
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(int duty, bit rnd, int abort_at, int start_at, int reset_at);
    int g = 0;
    pat_mode = !rnd;
    for (int i = 0; i < DEPTH; i++) tab[i] = rnd ? 8'($urandom) : 8'(i);
    start = 1'b1;
    tick();
    start = 1'b0;
    while (m_busy && g < 6000) begin
      s_valid = ($urandom_range(0, 99) < duty);
      s_data = tab[n < DEPTH ? n : 0];
      abort = (n == abort_at);
      start = (n == start_at);
      if (n == reset_at) begin
        rst_n = 1'b0;
        s_valid = 1'b0;
        abort = 1'b0;
        start = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        break;
      end
      tick();
      g++;
    end
    s_valid = 1'b0;
    abort = 1'b0;
    start = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    #3 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    run(100, 0, -1, -1, -1);
    run(50, 1, -1, -1, -1);
    run(50, 1, -1, 300, -1);
    run(100, 1, 512, -1, -1);
    run(100, 0, -1, -1, -1);
    run(100, 1, -1, -1, 100);
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    repeat (2) tick();
    if (RB) begin
      corrupt = 1'b1;
      run(100, 0, -1, -1, -1);
      corrupt = 1'b0;
    end
    run(60, 0, -1, -1, -1);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
